// File: rtl/peripheral_spram_arbiter_axi4.sv
// peripheral_spram_arbiter_axi4
//   Two-port arbiter in front of a single-port RAM with 1-cycle registered
//   read data. Ties are broken by a priority pointer; a port may hold
//   ownership via lock_i for at most LOCK_MAX consecutive grants while the
//   other port waits.
//
//   Build option: define PERIPHERAL_SPRAM_ARBITER_ROUND_ROBIN_EN for
//   round-robin tie-breaking. Otherwise the pointer stays on port 0, so
//   port 0 wins ties. Lock behaviour is identical in both builds.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   req_i/we_i/lock_i      per-port request, write enable, lock request
//   be_i/addr_i/wdata_i    per-port byte enables, word address, write data
//                          (port k uses slice k)
//   gnt_o                  combinational grant, one-hot or zero
//   rvalid_o               per-port read-data valid, one cycle after a read
//   rdata_o                shared read data (mem_rdata_i pass-through)
//   mem_*                  RAM side: granted port's fields, all 0 when idle
//
// State  | meaning
// IDLE   | no owner, plain pointer arbitration
// LOCK0  | port 0 holds ownership, lock_cnt counts its consecutive grants
// LOCK1  | port 1 holds ownership, lock_cnt counts its consecutive grants
module peripheral_spram_arbiter_axi4 #(
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int LOCK_MAX       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    req_i,
  input  logic [1:0]                    we_i,
  input  logic [1:0]                    lock_i,
  input  logic [2*AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [2*AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [2*AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BW = AXI_DATA_WIDTH / 8;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       ptr_q;
  logic [7:0] lock_cnt_q;
  logic [1:0] rvalid_q;

  logic [1:0] idle_gnt;
  logic [1:0] gnt;
  logic [1:0] xfer;
  logic       win;
  state_t     win_lock;

  always_comb begin
    idle_gnt = 2'b00;
    case (req_i)
      2'b01:   idle_gnt = 2'b01;
      2'b10:   idle_gnt = 2'b10;
      2'b11:   idle_gnt = ptr_q ? 2'b10 : 2'b01;
      default: idle_gnt = 2'b00;
    endcase
  end

  // The owner keeps the grant unless it has used up LOCK_MAX grants and the
  // other port is waiting. An owner that drops its request falls back to
  // pointer arbitration. Gating with rst_ni keeps the RAM quiet in reset.
  always_comb begin
    gnt = idle_gnt;
    if (state_q == LOCK0 && req_i[0]) begin
      gnt = (lock_cnt_q == LOCK_MAX_C && req_i[1]) ? 2'b10 : 2'b01;
    end else if (state_q == LOCK1 && req_i[1]) begin
      gnt = (lock_cnt_q == LOCK_MAX_C && req_i[0]) ? 2'b01 : 2'b10;
    end
    if (!rst_ni) gnt = 2'b00;
  end

  assign gnt_o    = gnt;
  assign xfer     = req_i & gnt;
  assign win      = xfer[1];
  assign win_lock = win ? LOCK1 : LOCK0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      lock_cnt_q <= 8'd0;
      rvalid_q   <= 2'b00;
    end else begin
      rvalid_q <= xfer & ~we_i;
      if (|xfer) begin
`ifdef PERIPHERAL_SPRAM_ARBITER_ROUND_ROBIN_EN
        ptr_q <= ~win;
`else
        ptr_q <= 1'b0;
`endif
        if (lock_i[win]) begin
          state_q <= win_lock;
          if (state_q == win_lock) begin
            lock_cnt_q <= (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 8'd1;
          end else begin
            lock_cnt_q <= 8'd1;
          end
        end else begin
          state_q    <= IDLE;
          lock_cnt_q <= 8'd0;
        end
      end else begin
        state_q    <= IDLE;
        lock_cnt_q <= 8'd0;
      end
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt[0]) begin
      mem_we_o    = we_i[0];
      mem_be_o    = be_i[0 +: BW];
      mem_addr_o  = addr_i[0 +: AXI_ADDR_WIDTH];
      mem_wdata_o = wdata_i[0 +: AXI_DATA_WIDTH];
    end else if (gnt[1]) begin
      mem_we_o    = we_i[1];
      mem_be_o    = be_i[BW +: BW];
      mem_addr_o  = addr_i[AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      mem_wdata_o = wdata_i[AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  assign mem_req_o = |gnt;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_peripheral_spram_arbiter_axi4.sv
// Bench for peripheral_spram_arbiter_axi4: directed scenarios followed by
// random traffic, checked cycle by cycle against a behavioural model of the
// arbitration rules and a shadow copy of the RAM contents.
module tb_peripheral_spram_arbiter_axi4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LOCK_MAX = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic [1:0]      req_i = '0, we_i = '0, lock_i = '0;
  logic [2*BW-1:0] be_i = '0;
  logic [2*AW-1:0] addr_i = '0;
  logic [2*DW-1:0] wdata_i = '0;
  logic [1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, mem_wdata_o;
  logic            mem_req_o, mem_we_o;
  logic [BW-1:0]   mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  peripheral_spram_arbiter_axi4 #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // RAM with registered read data
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  // behavioural model
  int            m_owner, m_cnt, m_ptr;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            checks = 0, errors = 0;
  int            last_w;
  logic [1:0]    obs_gnt, obs_rvalid;
  logic [DW-1:0] obs_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick();
    int o;
    if (m_owner >= 0 && req_i[m_owner]) begin
      o = 1 - m_owner;
      if (m_cnt == LOCK_MAX && req_i[o]) return o;
      return m_owner;
    end
    if (req_i == 2'b00) return -1;
    if (req_i == 2'b01) return 0;
    if (req_i == 2'b10) return 1;
    return m_ptr;
  endfunction

  task automatic ref_commit(input int w);
    logic [AW-1:0] a;
    if (w < 0) begin
      m_owner = -1; m_cnt = 0; m_rv = 2'b00;
      return;
    end
    if (lock_i[w]) begin
      if (m_owner == w) m_cnt = (m_cnt < LOCK_MAX) ? m_cnt + 1 : LOCK_MAX;
      else m_cnt = 1;
      m_owner = w;
    end else begin
      m_owner = -1; m_cnt = 0;
    end
`ifdef PERIPHERAL_SPRAM_ARBITER_ROUND_ROBIN_EN
    m_ptr = 1 - w;
`endif
    a = addr_i[w*AW +: AW];
    if (we_i[w]) begin
      m_rv = 2'b00;
      for (int b = 0; b < BW; b++)
        if (be_i[w*BW + b]) ref_mem[a][8*b +: 8] = wdata_i[w*DW + 8*b +: 8];
    end else begin
      m_rv = (w == 0) ? 2'b01 : 2'b10;
      m_rd = ref_mem[a];
    end
  endtask

  task automatic ref_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_rv = 2'b00;
  endtask

  task automatic set_port(input int k, input logic r, input logic w, input logic lk,
                          input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[k] = r; we_i[k] = w; lock_i[k] = lk;
    be_i[k*BW +: BW] = b; addr_i[k*AW +: AW] = a; wdata_i[k*DW +: DW] = d;
  endtask

  // one cycle: check outputs at negedge against the model, then commit
  task automatic step();
    int w;
    logic [1:0] eg;
    logic [46:0] em;
    @(negedge clk_i);
    w = ref_pick();
    eg = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    obs_gnt = gnt_o; obs_rvalid = rvalid_o; obs_rdata = rdata_o;
    check("gnt", 64'(gnt_o), 64'(eg));
    check("mem_req", 64'(mem_req_o), 64'(|eg));
    if (w < 0) em = '0;
    else em = {we_i[w], be_i[w*BW +: BW], addr_i[w*AW +: AW], wdata_i[w*DW +: DW]};
    check("mem_fields", 64'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(em));
    check("rvalid", 64'(rvalid_o), 64'(m_rv));
    if (m_rv != 2'b00) check("rdata", 64'(rdata_o), 64'(m_rd));
    last_w = w;
    @(posedge clk_i);
    ref_commit(w);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    ref_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic gen_txn(input int k);
    set_port(k, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
             BW'($urandom), AW'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    ref_reset();
    do_reset();

    // preload the random-traffic window through port 0
    for (int i = 0; i < 16; i++) begin
      set_port(0, 1'b1, 1'b1, 1'b0, 4'hF, AW'(i), $urandom);
      step();
    end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // port 0 writes, port 1 reads back
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h005, 32'hDEADBEEF);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, '0, 10'h005, '0);
    step();
    check("s1_gnt", 64'(obs_gnt), 64'h2);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("s1_rvalid", 64'(obs_rvalid), 64'h2);
    check("s1_rdata", 64'(obs_rdata), 64'hDEADBEEF);

    // both requesting, no lock, straight out of reset
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, '0, 10'h001, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, '0, 10'h002, '0);
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef PERIPHERAL_SPRAM_ARBITER_ROUND_ROBIN_EN
      check("tie_seq", 64'(obs_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
`else
      check("tie_seq", 64'(obs_gnt), 64'h1);
`endif
    end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();

    // port 1 locks, port 0 waits: LOCK_MAX grants then hand-over
    do_reset();
    set_port(1, 1'b1, 1'b0, 1'b1, '0, 10'h003, '0);
    step();
    check("lock_gnt0", 64'(obs_gnt), 64'h2);
    set_port(0, 1'b1, 1'b0, 1'b0, '0, 10'h004, '0);
    for (int i = 1; i < LOCK_MAX; i++) begin
      step();
      check("lock_gnt", 64'(obs_gnt), 64'h2);
    end
    step();
    check("lock_handover", 64'(obs_gnt), 64'h1);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();

    // partial byte-enable write
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h0A0, 32'h11223344);
    step();
    set_port(0, 1'b1, 1'b1, 1'b0, 4'b0010, 10'h0A0, 32'h0000AB00);
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h0A0, '0);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("be_rvalid", 64'(obs_rvalid), 64'h1);
    check("be_rdata", 64'(obs_rdata), 64'h1122AB44);

    // reset right after a read grant: no rvalid pulse
    set_port(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h0A0, '0);
    step();
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rstmid_rvalid", 64'(rvalid_o), 64'd0);
    check("rstmid_gnt", 64'(gnt_o), 64'd0);
    check("rstmid_mem_req", 64'(mem_req_o), 64'd0);
    ref_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    set_port(0, 1'b1, 1'b0, 1'b0, '0, 10'h001, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, '0, 10'h002, '0);
    step();
    check("rstmid_tie", 64'(obs_gnt), 64'h1);
    check("rstmid_no_rv", 64'(obs_rvalid), 64'd0);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();

    // random traffic; requesters hold their fields until granted
    gen_txn(0);
    gen_txn(1);
    for (int i = 0; i < 400; i++) begin
      step();
      for (int k = 0; k < 2; k++)
        if (last_w == k || !req_i[k]) gen_txn(k);
    end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/peripheral_spram_arbiter_axi4.md
PERIPHERAL_SPRAM_ARBITER_AXI4 -- requirements
Module: peripheral_spram_arbiter_axi4

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 10, meaning RAM word-address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning RAM data width, a multiple of 8.
REQ-003 SHALL have parameter LOCK_MAX, default 4, legal range 1..255, meaning the maximum number of consecutive locked grants to one port while the other port waits.
REQ-004 SHALL have one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- req_i  in  2  per-port access request; bit k belongs to port k.
- we_i  in  2  per-port write enable.
- lock_i  in  2  per-port request to keep ownership.
- be_i  in  2*AXI_DATA_WIDTH/8  byte enables; port k uses slice k.
- addr_i  in  2*AXI_ADDR_WIDTH  addresses; port k uses slice k.
- wdata_i  in  2*AXI_DATA_WIDTH  write data; port k uses slice k.
- gnt_o  out  2  grant; one-hot or zero.
- rvalid_o  out  2  read-data valid, per port.
- rdata_o  out  AXI_DATA_WIDTH  read data, shared by both ports.
- mem_req_o  out  1  RAM request.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  AXI_DATA_WIDTH/8  RAM byte enables.
- mem_addr_o  out  AXI_ADDR_WIDTH  RAM address.
- mem_wdata_o  out  AXI_DATA_WIDTH  RAM write data.
- mem_rdata_i  in  AXI_DATA_WIDTH  RAM registered read data.

Function
REQ-006 gnt_o SHALL be combinational from req_i, state, pointer and lock_cnt, and SHALL never have both bits high.
REQ-007 A transfer on port k SHALL complete at a rising edge where req_i[k] and gnt_o[k] are both high; requesters hold their inputs stable until granted.
REQ-008 mem_req_o SHALL equal the OR of gnt_o.
- mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL mux the granted port's fields.
- With no grant, all mem_* outputs SHALL be 0.
REQ-009 State machine SHALL have three states: IDLE, LOCK0, LOCK1.
REQ-010 In IDLE, with a single requester, that requester SHALL be granted; with both requesting, the port indicated by the priority pointer SHALL be granted.
REQ-011 In LOCKk with req_i[k]=1, port k SHALL be granted, except when lock_cnt equals LOCK_MAX and the other port is requesting; then the other port SHALL be granted.
- In LOCKk with req_i[k]=0, arbitration SHALL follow the IDLE rules in that cycle.
REQ-012 Next-state rules SHALL be:
- Enter or stay in LOCKk on a completed port-k transfer with lock_i[k]=1.
- Otherwise go to LOCKj on a completed port-j transfer with lock_i[j]=1.
- Otherwise go to IDLE.
REQ-013 lock_cnt (8 bits) SHALL:
- increment on each consecutive completed transfer by the locking owner;
- load 1 on entry to a LOCK state;
- clear to 0 in IDLE or on an owner change;
- saturate at LOCK_MAX.
REQ-014 The priority pointer SHALL point to the non-winning port after every completed transfer and SHALL be unchanged when no transfer completes.
REQ-015 rvalid_o[k] SHALL be registered: high for exactly one cycle after an edge that completed a read (we_i[k]=0) on port k; rvalid_o SHALL be 0 after write transfers.
REQ-016 rdata_o SHALL equal mem_rdata_i combinationally; it is meaningful only while a rvalid_o bit is high.
- Read latency is 1 cycle; back-to-back reads alternating between ports SHALL run at full throughput.

Reset
REQ-017 Assertion of rst_ni=0 SHALL asynchronously set: state IDLE, pointer to port 0, lock_cnt 0, rvalid_o 0.
- gnt_o and mem_* SHALL be 0 while in reset.
REQ-018 A read accepted in the cycle before reset assertion SHALL produce no rvalid_o pulse.

Configuration
REQ-019 Macro PERIPHERAL_SPRAM_ARBITER_ROUND_ROBIN_EN SHALL control pointer behaviour:
- Defined: the pointer behaves per REQ-014.
- Undefined: the pointer is tied to port 0 (fixed priority, port 0 wins ties), and LOCK and LOCK_MAX behaviour is unchanged.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Port 0 writes 0xDEADBEEF to address 0x005 with be=0xF, then port 1 reads 0x005 -> rvalid_o=2'b10 one cycle after the grant, rdata_o=0xDEADBEEF.
- Both ports request continuously with lock_i=0, macro defined -> grants alternate 0,1,0,1 starting at port 0 after reset.
- Same stimulus with macro undefined -> port 0 is granted every cycle and port 1 is never granted.
- Port 1 holds lock_i=1 with continuous requests, port 0 requesting, LOCK_MAX=4 -> port 1 is granted 4 consecutive cycles, then port 0 is granted.
- Port 0 write with be=4'b0010 and data 0x0000AB00 over 0x11223344 -> readback is 0x1122AB44.
- rst_ni dropped the cycle after a port-0 read grant -> no rvalid_o pulse, gnt_o=0, then after release both-request ties go to port 0.
